// File: rtl/tone_div_pkg.sv
// Shared types and constants for the tone divisor scheduler.
// Optional feature macro: TONE_DIV_OCTAVE_EN (octave scaling of the divisor).
package tone_div_pkg;

  localparam int unsigned FREQ_W    = 32;
  localparam int unsigned NDIV_W    = 22;
  localparam int unsigned OCT_W     = 3;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = 6;

  localparam int unsigned            DIVIDEND_DEFAULT    = 100_000_000;
  localparam logic [NDIV_W-1:0]      SILENCE_DIV_DEFAULT = 22'd1;
  localparam logic [NDIV_W-1:0]      DIV_SAT             = 22'h3FFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

  // Octave scaling of a raw tone frequency into the divider's divisor.
  function automatic logic [FREQ_W-1:0] eff_divisor(input logic [FREQ_W-1:0] freq,
                                                    input logic [OCT_W-1:0]  octave);
    logic [FREQ_W-1:0] d;
    case (octave)
      3'd1:    d = freq >> 1;
      3'd2:    d = freq;
      3'd3:    d = {freq[FREQ_W-2:0], 1'b0};
      default: d = freq;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock. The first step is taken on
// the start edge itself so the quotient is final 32 edges after start, with
// done pulsing high for the cycle that follows.
module seq_divider
  import tone_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FREQ_W-1:0] dividend,
  input  logic [FREQ_W-1:0] divisor,
  output logic              done,
  output logic [FREQ_W-1:0] quotient
);

  logic [FREQ_W-1:0] rem_q;
  logic [FREQ_W-1:0] quo_q;
  logic [FREQ_W-1:0] dsr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q;

  logic [FREQ_W-1:0] rem_src_c;
  logic [FREQ_W-1:0] quo_src_c;
  logic [FREQ_W-1:0] dsr_src_c;
  logic [FREQ_W:0]   rem_sh_c;
  logic [FREQ_W:0]   trial_c;
  logic [FREQ_W-1:0] rem_nxt_c;
  logic [FREQ_W-1:0] quo_nxt_c;

  // One shift-subtract step, seeded from the operands on start.
  always_comb begin
    rem_src_c = start ? '0 : rem_q;
    quo_src_c = start ? dividend : quo_q;
    dsr_src_c = start ? divisor : dsr_q;
    rem_sh_c  = {rem_src_c, quo_src_c[FREQ_W-1]};
    trial_c   = rem_sh_c - {1'b0, dsr_src_c};
    if (!trial_c[FREQ_W]) begin
      rem_nxt_c = trial_c[FREQ_W-1:0];
      quo_nxt_c = {quo_src_c[FREQ_W-2:0], 1'b1};
    end else begin
      rem_nxt_c = rem_sh_c[FREQ_W-1:0];
      quo_nxt_c = {quo_src_c[FREQ_W-2:0], 1'b0};
    end
  end

  // Iteration registers and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= rem_nxt_c;
        quo_q    <= quo_nxt_c;
        dsr_q    <= divisor;
        cnt_q    <= CNT_W'(1);
        active_q <= 1'b1;
      end else if (active_q) begin
        rem_q <= rem_nxt_c;
        quo_q <= quo_nxt_c;
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          active_q <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/tone_div_scheduler.sv
// Shares one sequential divider between the left and right tone channels,
// arbitrating round-robin and registering the resulting note_gen divisors.
// Optional feature macro: TONE_DIV_OCTAVE_EN (octave scales the divisor and
// octave changes re-trigger a computation).
module tone_div_scheduler
  import tone_div_pkg::*;
#(
  parameter logic [FREQ_W-1:0] DIVIDEND    = FREQ_W'(DIVIDEND_DEFAULT),
  parameter logic [NDIV_W-1:0] SILENCE_DIV = SILENCE_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq_l,
  input  logic [FREQ_W-1:0] freq_r,
  input  logic [OCT_W-1:0]  octave,
  output logic [NDIV_W-1:0] note_div_l,
  output logic [NDIV_W-1:0] note_div_r,
  output logic              busy,
  output logic              upd_l,
  output logic              upd_r
);

  state_e            state_q;
  state_e            state_d;
  chan_e             rr_q;
  chan_e             cur_q;
  logic              zero_q;
  logic [FREQ_W-1:0] last_freq_l_q;
  logic [FREQ_W-1:0] last_freq_r_q;
  logic              pend_l_q;
  logic              pend_r_q;
`ifdef TONE_DIV_OCTAVE_EN
  logic [OCT_W-1:0]  last_oct_l_q;
  logic [OCT_W-1:0]  last_oct_r_q;
`else
  logic              unused_octave;
  assign unused_octave = ^octave;
`endif

  logic              chg_l_c;
  logic              chg_r_c;
  logic [FREQ_W-1:0] eff_l_c;
  logic [FREQ_W-1:0] eff_r_c;
  logic              pend_l_c;
  logic              pend_r_c;
  logic              grant_c;
  chan_e             grant_ch_c;
  logic [FREQ_W-1:0] grant_div_c;
  logic              grant_zero_c;
  logic              div_start_c;
  logic              div_done;
  logic [FREQ_W-1:0] div_quot;
  logic [NDIV_W-1:0] result_c;

  // Change detection against the last accepted inputs, and effective divisors.
  always_comb begin
    chg_l_c = (freq_l != last_freq_l_q);
    chg_r_c = (freq_r != last_freq_r_q);
`ifdef TONE_DIV_OCTAVE_EN
    chg_l_c = chg_l_c || (octave != last_oct_l_q);
    chg_r_c = chg_r_c || (octave != last_oct_r_q);
    eff_l_c = eff_divisor(freq_l, octave);
    eff_r_c = eff_divisor(freq_r, octave);
`else
    eff_l_c = freq_l;
    eff_r_c = freq_r;
`endif
  end

  // Round-robin grant while idle; left wins ties when the pointer says so.
  always_comb begin
    pend_l_c = chg_l_c || pend_l_q;
    pend_r_c = chg_r_c || pend_r_q;
    grant_c  = (state_q == IDLE) && (pend_l_c || pend_r_c);
    if (pend_l_c && pend_r_c) begin
      grant_ch_c = rr_q;
    end else if (pend_l_c) begin
      grant_ch_c = LEFT;
    end else begin
      grant_ch_c = RIGHT;
    end
    grant_div_c  = (grant_ch_c == LEFT) ? eff_l_c : eff_r_c;
    grant_zero_c = (grant_div_c == '0);
    div_start_c  = grant_c && !grant_zero_c;
  end

  // Value to commit in WRITE: silence for a zero divisor, else clamped quotient.
  always_comb begin
    if (zero_q) begin
      result_c = SILENCE_DIV;
    end else if (div_quot > FREQ_W'(DIV_SAT)) begin
      result_c = DIV_SAT;
    end else begin
      result_c = div_quot[NDIV_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_c) state_d = grant_zero_c ? WRITE : DIV;
      DIV:     if (div_done) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; busy mirrors the non-idle states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Grant bookkeeping: last accepted inputs, pending flags, pointer, job info.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q          <= LEFT;
      cur_q         <= LEFT;
      zero_q        <= 1'b0;
      last_freq_l_q <= '0;
      last_freq_r_q <= '0;
      pend_l_q      <= 1'b1;
      pend_r_q      <= 1'b1;
`ifdef TONE_DIV_OCTAVE_EN
      last_oct_l_q  <= '0;
      last_oct_r_q  <= '0;
`endif
    end else if (grant_c) begin
      rr_q   <= (grant_ch_c == LEFT) ? RIGHT : LEFT;
      cur_q  <= grant_ch_c;
      zero_q <= grant_zero_c;
      if (grant_ch_c == LEFT) begin
        last_freq_l_q <= freq_l;
        pend_l_q      <= 1'b0;
`ifdef TONE_DIV_OCTAVE_EN
        last_oct_l_q  <= octave;
`endif
      end else begin
        last_freq_r_q <= freq_r;
        pend_r_q      <= 1'b0;
`ifdef TONE_DIV_OCTAVE_EN
        last_oct_r_q  <= octave;
`endif
      end
    end
  end

  // Output divisor registers and their one-cycle update strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_div_l <= SILENCE_DIV;
      note_div_r <= SILENCE_DIV;
      upd_l      <= 1'b0;
      upd_r      <= 1'b0;
    end else begin
      upd_l <= 1'b0;
      upd_r <= 1'b0;
      if (state_q == WRITE) begin
        if (cur_q == LEFT) begin
          note_div_l <= result_c;
          upd_l      <= 1'b1;
        end else begin
          note_div_r <= result_c;
          upd_r      <= 1'b1;
        end
      end
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (DIVIDEND),
    .divisor  (grant_div_c),
    .done     (div_done),
    .quotient (div_quot)
  );

endmodule

// File: tb/tb_tone_div_scheduler.sv
// Bench for tone_div_scheduler: directed scenarios plus random input churn,
// compared every cycle against a transaction-level reference model.
// Optional feature macro: TONE_DIV_OCTAVE_EN (must match the RTL build).
module tb_tone_div_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] freq_l;
  logic [31:0] freq_r;
  logic [2:0]  octave;
  logic [21:0] note_div_l;
  logic [21:0] note_div_r;
  logic        busy;
  logic        upd_l;
  logic        upd_r;

  int errors = 0;
  int checks = 0;

  // Reference model state: channel 0 = left, 1 = right.
  logic [21:0] m_div [2];
  logic        m_upd [2];
  logic [31:0] m_last_f [2];
  logic        m_pend [2];
`ifdef TONE_DIV_OCTAVE_EN
  logic [2:0]  m_last_o [2];
`endif
  int          m_timer;
  int          m_ch;
  int          m_rr;
  logic [21:0] m_res;

  tone_div_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .freq_l     (freq_l),
    .freq_r     (freq_r),
    .octave     (octave),
    .note_div_l (note_div_l),
    .note_div_r (note_div_r),
    .busy       (busy),
    .upd_l      (upd_l),
    .upd_r      (upd_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] eff(input logic [31:0] f);
`ifdef TONE_DIV_OCTAVE_EN
    if (octave == 3'd1) return f / 2;
    if (octave == 3'd3) return f * 2;
`endif
    return f;
  endfunction

  function automatic logic [21:0] div_result(input logic [31:0] d);
    logic [31:0] q;
    if (d == 0) return 22'd1;
    q = 32'd100_000_000 / d;
    if (q > 32'd4194303) return 22'h3FFFFF;
    return q[21:0];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_div[c]    = 22'd1;
      m_upd[c]    = 1'b0;
      m_last_f[c] = '0;
      m_pend[c]   = 1'b1;
`ifdef TONE_DIV_OCTAVE_EN
      m_last_o[c] = '0;
`endif
    end
    m_timer = 0;
    m_ch    = 0;
    m_rr    = 0;
    m_res   = '0;
  endtask

  // One clock edge of the model: a granted job completes a fixed number of
  // edges later (33 for a real division, 1 for the silence shortcut).
  task automatic model_edge();
    logic [31:0] f [2];
    logic        p [2];
    logic [31:0] d;
    int          c;
    m_upd[0] = 1'b0;
    m_upd[1] = 1'b0;
    if (m_timer != 0) begin
      m_timer--;
      if (m_timer == 0) begin
        m_div[m_ch] = m_res;
        m_upd[m_ch] = 1'b1;
      end
    end else begin
      f[0] = freq_l;
      f[1] = freq_r;
      for (int k = 0; k < 2; k++) begin
        p[k] = m_pend[k] || (f[k] != m_last_f[k]);
`ifdef TONE_DIV_OCTAVE_EN
        p[k] = p[k] || (octave != m_last_o[k]);
`endif
      end
      if (p[0] || p[1]) begin
        c = (p[0] && p[1]) ? m_rr : (p[0] ? 0 : 1);
        m_rr        = 1 - c;
        m_last_f[c] = f[c];
        m_pend[c]   = 1'b0;
`ifdef TONE_DIV_OCTAVE_EN
        m_last_o[c] = octave;
`endif
        d       = eff(f[c]);
        m_res   = div_result(d);
        m_timer = (d == 0) ? 1 : 33;
        m_ch    = c;
      end
    end
  endtask

  task automatic compare_all();
    check("note_div_l", 32'(note_div_l), 32'(m_div[0]));
    check("note_div_r", 32'(note_div_r), 32'(m_div[1]));
    check("busy",       32'(busy),       32'(m_timer != 0));
    check("upd_l",      32'(upd_l),      32'(m_upd[0]));
    check("upd_r",      32'(upd_r),      32'(m_upd[1]));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      #1;
      compare_all();
    end
  endtask

  function automatic logic [31:0] rand_freq();
    case ($urandom % 7)
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 30));
      2:       return 32'($urandom_range(200, 5000));
      3:       return 32'd440;
      4:       return 32'hFFFF_FFFF;
      5:       return 32'($urandom_range(23, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    // Reset with both channels at 440 Hz, octave 2.
    rst    = 1'b1;
    freq_l = 32'd440;
    freq_r = 32'd440;
    octave = 3'd2;
    model_reset();
    #2;
    compare_all();
    check("rst_div_l", 32'(note_div_l), 32'd1);
    tick(2);
    rst = 1'b0;

    // Left written on edge 34, right on edge 68.
    tick(33);
    check("l_before_34", 32'(upd_l), 32'd0);
    tick(1);
    check("l_440", 32'(note_div_l), 32'd227272);
    check("l_upd_34", 32'(upd_l), 32'd1);
    tick(33);
    check("r_before_68", 32'(upd_r), 32'd0);
    tick(1);
    check("r_440", 32'(note_div_r), 32'd227272);
    check("r_upd_68", 32'(upd_r), 32'd1);

    // Zero divisor: silence two edges after the change.
    freq_l = 32'd0;
    tick(1);
    check("zero_busy", 32'(busy), 32'd1);
    tick(1);
    check("zero_div", 32'(note_div_l), 32'd1);
    check("zero_upd", 32'(upd_l), 32'd1);

    // Saturation.
    freq_l = 32'd20;
    tick(34);
    check("sat_div", 32'(note_div_l), 32'h3FFFFF);

    // Change during division: stale result first, then the new one.
    freq_l = 32'd440;
    tick(10);
    freq_l = 32'd494;
    tick(24);
    check("stale_440", 32'(note_div_l), 32'd227272);
    tick(34);
    check("fresh_494", 32'(note_div_l), 32'd202429);

    // Octave cases (only scale when the feature is built in).
    freq_r = 32'd262;
    octave = 3'd1;
    tick(80);
`ifdef TONE_DIV_OCTAVE_EN
    check("r_262_oct1", 32'(note_div_r), 32'd763358);
`else
    check("r_262_oct1", 32'(note_div_r), 32'd381679);
`endif
    freq_l = 32'd440;
    octave = 3'd3;
    tick(80);
`ifdef TONE_DIV_OCTAVE_EN
    check("l_440_oct3", 32'(note_div_l), 32'd113636);
`else
    check("l_440_oct3", 32'(note_div_l), 32'd227272);
`endif
    octave = 3'd2;
    tick(80);

    // Reset in the middle of a division.
    freq_r = 32'd300;
    tick(16);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("mrst_l", 32'(note_div_l), 32'd1);
    check("mrst_r", 32'(note_div_r), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(80);
    check("post_rst_l", 32'(note_div_l), 32'd227272);
    check("post_rst_r", 32'(note_div_r), 32'd333333);

    // Random churn on both channels, octave and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 40 == 0) freq_l = rand_freq();
      if ($urandom % 40 == 0) freq_r = rand_freq();
      if ($urandom % 30 == 0) begin
        freq_l = rand_freq();
        freq_r = rand_freq();
      end
      if ($urandom % 60 == 0) octave = 3'($urandom);
      if ($urandom % 700 == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        tick(1);
        rst = 1'b0;
      end
      tick(1);
    end
    tick(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_div_scheduler.md
TONE_DIV_SCHEDULER -- requirements
Module: tone_div_scheduler

Interface
REQ-001 SHALL expose parameter DIVIDEND, default 100_000_000, numerator of every tone-divisor computation.
REQ-002 SHALL expose parameter SILENCE_DIV, default 22'd1, divisor value that note_gen treats as silence.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port freq_l  input  32  left raw tone frequency from music module.
REQ-006 SHALL have port freq_r  input  32  right raw tone frequency.
REQ-007 SHALL have port octave  input  3  octave select from volume_octave_controller.
REQ-008 SHALL have port note_div_l  output  22  registered left divisor to note_gen.
REQ-009 SHALL have port note_div_r  output  22  registered right divisor to note_gen.
REQ-010 SHALL have port busy  output  1  high while a division is in flight.
REQ-011 SHALL have port upd_l, upd_r  output  1 each  one-cycle pulse when the matching note_div register is written.

Function
REQ-012 SHALL replace the two combinational dividers with one shared 32-bit restoring divider, one quotient bit per cycle.
REQ-013 SHALL keep per-channel "last accepted" copies of {freq, octave}; channel pending = (current inputs != last accepted) or pending flag set.
REQ-014 SHALL run FSM IDLE -> DIV (32 cycles) -> WRITE (1 cycle) -> IDLE; zero-divisor path IDLE -> WRITE directly.
REQ-015 In IDLE with any channel pending, SHALL grant by round-robin (pointer starts LEFT after reset, flips to the other channel after every grant), latch that channel's inputs as last accepted, and clear its pending flag.
REQ-016 Effective divisor SHALL be: octave 1 -> freq>>1; octave 2 -> freq; octave 3 -> freq<<1 (32-bit, MSB dropped); any other octave -> freq.
REQ-017 Effective divisor 0 SHALL produce SILENCE_DIV without running the divider.
REQ-018 Quotient > 22'h3FFFFF SHALL saturate to 22'h3FFFFF; otherwise the low 22 bits SHALL be written.
REQ-019 Latency: inputs changed while IDLE and granted -> note_div updated at the 34th rising edge after the change; zero-divisor case at the 2nd edge.
REQ-020 Input change on the channel being divided SHALL NOT abort it; the stale result is written, the channel re-pends, and is recomputed on a later grant.
REQ-021 Both channels changing in the same cycle SHALL be served back to back, with no idle cycle between WRITE and the next grant.
REQ-022 Outputs SHALL hold their last written value at all times other than WRITE.
REQ-023 busy SHALL be high in DIV and WRITE, low in IDLE.

Reset
REQ-024 On rst SHALL force state IDLE, note_div_l = note_div_r = SILENCE_DIV, busy = 0, upd_l = upd_r = 0, pending flags set for both channels, last-accepted copies = 0, RR pointer = LEFT.
REQ-025 rst asserted mid-division SHALL discard the partial quotient; no output write occurs.

Configuration
REQ-026 With macro TONE_DIV_OCTAVE_EN defined, REQ-016 octave scaling SHALL apply and octave changes SHALL set pending.
REQ-027 Without TONE_DIV_OCTAVE_EN, octave SHALL be ignored (effective divisor = freq, not part of the change compare).

Structure
REQ-028 Package tone_div_pkg SHALL hold the FSM state enum (IDLE, DIV, WRITE), channel enum (LEFT, RIGHT), DIVIDEND default, SILENCE_DIV, and 22'h3FFFFF saturation constant.
REQ-029 The divider datapath SHALL be a sub-module seq_divider (start/done handshake, 32-bit dividend and divisor, 32-bit quotient); the scheduler SHALL own arbitration and the output registers.

Verification
REQ-030 After reset, freq_l=440, freq_r=440, octave=2 -> note_div_l=227272 (upd_l at edge 34), then note_div_r=227272 (upd_r at edge 68).
REQ-031 freq_r=262, octave=1 -> divisor 131 -> note_div_r=763358; octave=3, freq_l=440 -> note_div_l=113636.
REQ-032 freq_l=0 -> note_div_l=1 two edges after the change; freq_l=20, octave=2 -> saturated 22'h3FFFFF.
REQ-033 freq_l changes 440->494 at DIV cycle 10 -> 227272 written first, then 202429 written next grant.
REQ-034 rst pulsed at DIV cycle 16 -> outputs return to 1, busy=0, no upd pulse; both channels recomputed after release.
